sprite_scheduler: RTL and testbench
===================================

Name: sprite_scheduler

Overview:
- Per-scanline sprite scheduler sitting between the CPU bus and a bank of single-sprite pixel engines.
- Owns the sprite attribute table: X/Y per sprite, CPU-writable.
- On each hsync it scans the table, finds the sprites visible on the next scanline, and loads up to NUM_SLOTS of them into the pixel-engine slots (sprite id, X, row).
- Arbitrates the single-port attribute RAM between the CPU and the scanner. The CPU has priority.

Parameters:
- NUM_SPRITES, 8, number of table entries (power of 2, max 8; table = 2*NUM_SPRITES bytes).
- NUM_SLOTS, 4, number of pixel-engine slots filled per line (1..8).
- SPRITE_H, 8, sprite height in lines (power of 2, max 8).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  CPU chip select
- rw  in  1  1 = write, 0 = read (valid with cs)
- addr  in  4  table byte address: even = Y of sprite addr[3:1], odd = X
- di  in  8  CPU write data
- dout  out  8  CPU read data, registered
- vpos  in  7  current scanline
- hsync  in  1  horizontal sync, level
- vsync  in  1  vertical sync, level
- slot_load  out  1  one-cycle strobe: slot fields valid
- slot_idx  out  3  slot being loaded
- slot_id  out  3  sprite number loaded
- slot_x  out  8  sprite X
- slot_row  out  3  row within sprite bitmap for next line
- slot_valid  out  NUM_SLOTS  slots loaded for the upcoming line
- overflow  out  1  sticky: more than NUM_SLOTS sprites visible on some line this frame
- busy  out  1  scan in progress

Behaviour:
- Reset (async, any state): FSM = IDLE, dout = 0, slot_load = 0, slot_idx/id/x/row = 0, slot_valid = 0, overflow = 0, busy = 0, edge-detect regs = 0. RAM contents are not reset.
- CPU access:
  - cs & rw writes di to ram[addr] at the clock edge.
  - cs & ~rw gives dout <= ram[addr] on the next edge, 1-cycle latency.
  - dout holds its value otherwise.
  - The CPU wins every cycle it asserts cs. The scanner stalls that cycle: no state, counter or output change except slot_load forced to 0.
- Edge detection:
  - hsync and vsync are registered once.
  - A rise is prev = 0, cur = 1.
  - A vsync rise clears overflow. If a set of overflow occurs in the same cycle, the set wins.
- FSM states IDLE, RD_Y, RD_X, DONE:
  - IDLE: on hsync rise: target <= {1'b0,vpos} + 1 (8-bit, so 127 -> 128), sprite counter n <= 0, slot counter k <= 0, slot_valid <= 0, busy <= 1, go to RD_Y.
  - RD_Y:
    - dy = target - ram[2n], 8-bit modular.
    - Visible iff dy < SPRITE_H.
    - Visible and k < NUM_SLOTS: latch row = dy[2:0], go to RD_X.
    - Visible and k == NUM_SLOTS: overflow <= 1, then treat as not visible.
    - Not visible: n == NUM_SPRITES-1 goes to DONE; otherwise n++ and stay.
  - RD_X:
    - slot_load <= 1, slot_idx <= k, slot_id <= n, slot_x <= ram[2n+1], slot_row <= row, slot_valid[k] <= 1, k++.
    - Then same n-advance/DONE rule as RD_Y.
  - DONE: busy <= 0, go to IDLE.
- An hsync rise outside IDLE is ignored; the scan in progress completes.
- Priority is lowest sprite number first.
- Scan latency, no stalls: NUM_SPRITES + (visible slots loaded) + 1 cycles from the first RD_Y.
- A CPU write to an entry during the scan takes effect if that entry has not yet been read.

Decomposition:
- Shared package sprite_pkg:
  - FSM state enum.
  - Table address helpers: Y offset 0, X offset 1.
  - Constants SPRITE_H_DEFAULT, MAX_SPRITES = 8.
- One sub-module, sprite_attr_ram: 16x8 single-port RAM with registered read.
  - Address mux (CPU vs scanner) stays in the top level.

Test Plan:
1. Write Y = {10, 50, 12, 200, …}, X = {20, 30, 40, …}; hsync rise at vpos = 13 (target 14) -> loads (slot0: id0, x20, row4), (slot1: id2, x40, row2); slot_valid = 0011; overflow = 0; busy drops after 8 + 2 + 1 cycles.
2. Set all 8 Y = 30; scan at vpos = 29 -> slots 0..3 = ids 0..3, row 0; overflow = 1. Next vsync rise clears it.
3. Hold cs = 1 (reads) for 5 cycles mid-scan -> the scan completes exactly 5 cycles later with identical slot results; dout returns each addressed byte one cycle after the request.
4. Y = 127 with scan at vpos = 126 -> row 0. Y = 0 with scan at vpos = 127 (target 128) -> not visible. Y = 250 with scan at vpos = 0 (dy = 7) -> row 7, confirming 8-bit modular wrap.
5. Assert reset during RD_X -> all outputs 0 immediately, without waiting for a clock edge; the next hsync rise starts a clean scan.
6. Second hsync rise while busy -> ignored; slot results are unchanged from a single scan.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and table-address helpers for the sprite scheduler slice.
package sprite_pkg;

  localparam int unsigned MAX_SPRITES      = 8;
  localparam int unsigned SPRITE_H_DEFAULT = 8;

  localparam logic Y_OFS = 1'b0;
  localparam logic X_OFS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_Y = 2'd1,
    RD_X = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] y_addr(input logic [2:0] n);
    return {n, Y_OFS};
  endfunction

  function automatic logic [3:0] x_addr(input logic [2:0] n);
    return {n, X_OFS};
  endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// 16x8 single-port sprite attribute RAM; q is the registered CPU read port,
// rdata is the same-cycle view used by the scanner while it owns the port.
module sprite_attr_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic       re,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] q,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (re) q <= mem[addr];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table on each hsync rise
// and loads the lowest-numbered visible sprites into the pixel-engine slots.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned SPRITE_H    = SPRITE_H_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 rw,
  input  logic [3:0]           addr,
  input  logic [7:0]           di,
  output logic [7:0]           dout,
  input  logic [6:0]           vpos,
  input  logic                 hsync,
  input  logic                 vsync,
  output logic                 slot_load,
  output logic [2:0]           slot_idx,
  output logic [2:0]           slot_id,
  output logic [7:0]           slot_x,
  output logic [2:0]           slot_row,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [NUM_SLOTS-1:0] ONE_SLOT = NUM_SLOTS'(1);

  state_t      state;
  logic [7:0]  target;
  logic [2:0]  n;
  logic [3:0]  k;
  logic [2:0]  row;
  logic        hs_cur, hs_prev, vs_cur, vs_prev;
  logic        hs_rise, vs_rise;

  logic [3:0]  scan_addr;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  dy;
  logic        visible, last, slots_free;

  assign hs_rise = hs_cur & ~hs_prev;
  assign vs_rise = vs_cur & ~vs_prev;

  // The CPU owns the port whenever cs is high; the scanner is frozen then.
  assign scan_addr = (state == RD_X) ? x_addr(n) : y_addr(n);
  assign ram_addr  = cs ? addr : scan_addr;

  assign dy         = target - ram_rdata;
  assign visible    = dy < 8'(SPRITE_H);
  assign last       = (n == 3'(NUM_SPRITES - 1));
  assign slots_free = k < 4'(NUM_SLOTS);

  sprite_attr_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (cs & rw),
    .re    (cs & ~rw),
    .addr  (ram_addr),
    .wdata (di),
    .q     (dout),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target     <= '0;
      n          <= '0;
      k          <= '0;
      row        <= '0;
      hs_cur     <= 1'b0;
      hs_prev    <= 1'b0;
      vs_cur     <= 1'b0;
      vs_prev    <= 1'b0;
      slot_load  <= 1'b0;
      slot_idx   <= '0;
      slot_id    <= '0;
      slot_x     <= '0;
      slot_row   <= '0;
      slot_valid <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      hs_cur    <= hsync;
      hs_prev   <= hs_cur;
      vs_cur    <= vsync;
      vs_prev   <= vs_cur;
      slot_load <= 1'b0;

      // Clear precedes the scanner so a same-cycle overflow set wins.
      if (vs_rise) overflow <= 1'b0;

      if (!cs) begin
        unique case (state)
          IDLE: begin
            if (hs_rise) begin
              target     <= {1'b0, vpos} + 8'd1;
              n          <= '0;
              k          <= '0;
              slot_valid <= '0;
              busy       <= 1'b1;
              state      <= RD_Y;
            end
          end
          RD_Y: begin
            if (visible && slots_free) begin
              row   <= dy[2:0];
              state <= RD_X;
            end else begin
              if (visible) overflow <= 1'b1;
              if (last) state <= DONE;
              else      n     <= n + 3'd1;
            end
          end
          RD_X: begin
            slot_load  <= 1'b1;
            slot_idx   <= k[2:0];
            slot_id    <= n;
            slot_x     <= ram_rdata;
            slot_row   <= row;
            slot_valid <= slot_valid | (ONE_SLOT << k);
            k          <= k + 4'd1;
            if (last) begin
              state <= DONE;
            end else begin
              n     <= n + 3'd1;
              state <= RD_Y;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed cases plus randomized
// tables checked against a list-based visibility model.
module tb_sprite_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, rw;
  logic [3:0] addr;
  logic [7:0] di;
  logic [7:0] dout;
  logic [6:0] vpos;
  logic       hsync, vsync;
  logic       slot_load;
  logic [2:0] slot_idx, slot_id, slot_row;
  logic [7:0] slot_x;
  logic [3:0] slot_valid;
  logic       overflow, busy;

  sprite_scheduler #(.NUM_SPRITES(8), .NUM_SLOTS(4), .SPRITE_H(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .di(di),
    .dout(dout), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .slot_load(slot_load), .slot_idx(slot_idx), .slot_id(slot_id),
    .slot_x(slot_x), .slot_row(slot_row), .slot_valid(slot_valid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mem_m [16];
  logic        ovf_m;
  logic [16:0] got_q [$];
  logic [16:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (slot_load === 1'b1) got_q.push_back({slot_idx, slot_id, slot_x, slot_row});
  end

  function automatic logic [31:0] outs();
    return {dout, slot_load, slot_idx, slot_id, slot_x, slot_row, slot_valid, overflow, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int a, input int d);
    cs = 1'b1; rw = 1'b1; addr = 4'(a); di = 8'(d);
    tick();
    cs = 1'b0;
    mem_m[a] = 8'(d);
  endtask

  task automatic cpu_read(input int a);
    cs = 1'b1; rw = 1'b0; addr = 4'(a);
    tick();
    cs = 1'b0;
    check_eq("cpu_read", {24'd0, dout}, {24'd0, mem_m[a]});
    tick();
    check_eq("dout_hold", {24'd0, dout}, {24'd0, mem_m[a]});
  endtask

  task automatic load_table(input int ys[8], input int xs[8]);
    for (int i = 0; i < 8; i++) begin
      cpu_write(2 * i, ys[i]);
      cpu_write(2 * i + 1, xs[i]);
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick();
    ovf_m = 1'b0;
    check_eq("ovf_vsync_clear", {31'd0, overflow}, 32'd0);
  endtask

  task automatic do_scan(input int vp, input int stall_at, input int stall_len, input bit double_hs);
    int t, dy, loaded, cyc, ra;
    bit rd, done;
    exp_q.delete();
    got_q.delete();
    loaded = 0;
    t = vp + 1;
    for (int i = 0; i < 8; i++) begin
      dy = (t - int'(mem_m[2 * i])) & 255;
      if (dy < 8) begin
        if (loaded < 4) begin
          exp_q.push_back({3'(loaded), 3'(i), mem_m[2 * i + 1], 3'(dy)});
          loaded++;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end

    vpos = 7'(vp);
    hsync = 1'b1;
    tick(); tick();
    hsync = 1'b0;
    check_eq("busy_start", {31'd0, busy}, 32'd1);

    cyc = 0; done = 1'b0; ra = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      rd = (c >= stall_at) && (c < stall_at + stall_len);
      if (rd) begin
        ra = int'($urandom_range(0, 15));
        cs = 1'b1; rw = 1'b0; addr = 4'(ra);
      end else begin
        cs = 1'b0;
      end
      if (double_hs && c == 2) hsync = 1'b1;
      if (double_hs && c == 4) hsync = 1'b0;
      tick();
      cyc = c + 1;
      if (rd) check_eq("stall_dout", {24'd0, dout}, {24'd0, mem_m[ra]});
      if (!busy) done = 1'b1;
    end
    cs = 1'b0;
    hsync = 1'b0;

    check_eq("scan_len", cyc, 9 + loaded + stall_len);
    check_eq("load_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq("slot_fields", {15'd0, got_q[i]}, {15'd0, exp_q[i]});
    check_eq("slot_valid", {28'd0, slot_valid}, (32'd1 << loaded) - 32'd1);
    check_eq("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    tick(); tick();
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ys[8];
    int xs[8];
    int vp, t;

    reset = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; di = '0;
    vpos = '0; hsync = 1'b0; vsync = 1'b0; ovf_m = 1'b0;
    tick(); tick();
    check_eq("reset_state", outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Case 1: two visible sprites, then a read-back.
    ys = '{10, 50, 12, 200, 100, 100, 100, 100};
    xs = '{20, 30, 40, 50, 60, 70, 80, 90};
    load_table(ys, xs);
    cpu_read(5);
    do_scan(13, 0, 0, 1'b0);

    // Case 3: 5-cycle CPU read stall mid-scan.
    do_scan(13, 3, 5, 1'b0);

    // Case 6: second hsync rise while busy.
    do_scan(13, 0, 0, 1'b1);

    // Case 2: all sprites on one line -> overflow, then vsync clears it.
    ys = '{30, 30, 30, 30, 30, 30, 30, 30};
    load_table(ys, xs);
    do_scan(29, 0, 0, 1'b0);
    vsync_pulse();

    // Case 4: 8-bit target/dy boundaries.
    ys = '{127, 100, 100, 100, 100, 100, 100, 100};
    load_table(ys, xs);
    do_scan(126, 0, 0, 1'b0);
    cpu_write(0, 0);
    do_scan(127, 0, 0, 1'b0);
    cpu_write(0, 250);
    do_scan(0, 0, 0, 1'b0);

    // Case 5: async reset while in RD_X.
    ys = '{40, 100, 100, 100, 100, 100, 100, 100};
    xs = '{85, 1, 2, 3, 4, 5, 6, 7};
    load_table(ys, xs);
    cpu_read(1);
    vpos = 7'd40;
    hsync = 1'b1;
    tick(); tick();
    hsync = 1'b0;
    tick();
    check_eq("busy_pre_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1 check_eq("async_reset", outs(), 32'd0);
    tick();
    reset = 1'b0;
    ovf_m = 1'b0;
    tick();
    do_scan(40, 0, 0, 1'b0);

    // Randomized tables biased toward visibility around the target line.
    for (int it = 0; it < 16; it++) begin
      vp = int'($urandom_range(0, 127));
      t = vp + 1;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) ys[i] = (t - int'($urandom_range(0, 9))) & 255;
        else                           ys[i] = int'($urandom_range(0, 255));
        xs[i] = int'($urandom_range(0, 255));
      end
      load_table(ys, xs);
      if ($urandom_range(0, 3) == 0) vsync_pulse();
      if ($urandom_range(0, 1) == 1)
        do_scan(vp, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), 1'b0);
      else
        do_scan(vp, 0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
